// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - calculator instruction sequencer, 4x8 register file, shift-add multiplier, hex UART sender
module calc_seq_ctrl #(
  parameter bit NL_EN     = 1'b1,
  parameter bit HEX_UPPER = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] inst_wd,
  input  logic       inst_vld,
  input  logic       tx_rdy,
  output logic [7:0] tx_data,
  output logic       tx_vld,
  output logic       busy,
  output logic       inst_drop,
  output logic [7:0] led
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MUL, S_TX_HI, S_TX_LO, S_TX_CR, S_TX_LF
  } state_t;

  state_t     state, state_nx;
  logic [7:0] regs [4];
  logic [1:0] ra_q;
  logic [1:0] op_q;
  logic [3:0] immd_q;
  logic [7:0] b_q;
  logic [7:0] c_q;
  logic [7:0] acc;
  logic [2:0] cnt;
  logic [7:0] acc_nx;
  logic [7:0] exec_val;
  logic       accept;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return (HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
  endfunction

  assign accept   = inst_vld && (state == S_IDLE);
  // b_q doubles as the shifting multiplicand, c_q as the shifting multiplier
  assign acc_nx   = acc + (c_q[0] ? b_q : 8'd0);
  assign exec_val = (op_q == 2'b00) ? {regs[ra_q][3:0], immd_q} : b_q + c_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (inst_vld) begin
          case (inst_wd[7:6])
            2'b11:   state_nx = S_TX_HI;
            2'b10:   state_nx = S_MUL;
            default: state_nx = S_EXEC;
          endcase
        end
      end
      S_EXEC:  state_nx = S_IDLE;
      S_MUL:   if (cnt == 3'd7) state_nx = S_IDLE;
      S_TX_HI: if (tx_rdy) state_nx = S_TX_LO;
      S_TX_LO: if (tx_rdy) state_nx = NL_EN ? S_TX_CR : S_IDLE;
      S_TX_CR: if (tx_rdy) state_nx = S_TX_LF;
      S_TX_LF: if (tx_rdy) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    tx_vld  = 1'b0;
    tx_data = 8'h00;
    case (state)
      S_TX_HI: begin tx_vld = 1'b1; tx_data = hex_char(regs[ra_q][7:4]); end
      S_TX_LO: begin tx_vld = 1'b1; tx_data = hex_char(regs[ra_q][3:0]); end
      S_TX_CR: begin tx_vld = 1'b1; tx_data = 8'h0D; end
      S_TX_LF: begin tx_vld = 1'b1; tx_data = 8'h0A; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      led       <= 8'h00;
      inst_drop <= 1'b0;
      ra_q      <= 2'd0;
      op_q      <= 2'd0;
      immd_q    <= 4'h0;
      b_q       <= 8'h00;
      c_q       <= 8'h00;
      acc       <= 8'h00;
      cnt       <= 3'd0;
    end else begin
      inst_drop <= inst_vld && (state != S_IDLE);
      if (accept) begin
        ra_q   <= inst_wd[5:4];
        op_q   <= inst_wd[7:6];
        immd_q <= inst_wd[3:0];
        b_q    <= regs[inst_wd[3:2]];
        c_q    <= regs[inst_wd[1:0]];
        acc    <= 8'h00;
        cnt    <= 3'd0;
      end
      case (state)
        S_EXEC: begin
          regs[ra_q] <= exec_val;
          led        <= exec_val;
        end
        S_MUL: begin
          acc <= acc_nx;
          b_q <= {b_q[6:0], 1'b0};
          c_q <= {1'b0, c_q[7:1]};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            regs[ra_q] <= acc_nx;
            led        <= acc_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb/tb_calc_seq_ctrl.sv - randomized bench for calc_seq_ctrl against a register-file reference model
module tb_calc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] inst_wd;
  logic       inst_vld;
  logic       tx_rdy;
  logic [7:0] tx_data, led, tx_data2, led2;
  logic       tx_vld, busy, inst_drop, tx_vld2, busy2, inst_drop2;

  int checks = 0;
  int failures = 0;

  logic [7:0] mdl [4];
  logic [7:0] led_m;
  logic [7:0] got1 [16];
  logic [7:0] got2 [16];
  int n1, n2, hold_err, cyc;

  always #5 clk = ~clk;

  calc_seq_ctrl #(.NL_EN(1'b1), .HEX_UPPER(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .inst_wd(inst_wd), .inst_vld(inst_vld), .tx_rdy(tx_rdy),
    .tx_data(tx_data), .tx_vld(tx_vld), .busy(busy), .inst_drop(inst_drop), .led(led)
  );

  calc_seq_ctrl #(.NL_EN(1'b0), .HEX_UPPER(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .inst_wd(inst_wd), .inst_vld(inst_vld), .tx_rdy(tx_rdy),
    .tx_data(tx_data2), .tx_vld(tx_vld2), .busy(busy2), .inst_drop(inst_drop2), .led(led2)
  );

  function automatic logic [7:0] exp_byte(input logic [7:0] v, input int idx, input bit upper);
    string hu;
    string hl;
    logic [3:0] nib;
    hu  = "0123456789ABCDEF";
    hl  = "0123456789abcdef";
    nib = (idx == 0) ? v[7:4] : v[3:0];
    if (idx == 2) return 8'h0D;
    if (idx == 3) return 8'h0A;
    return upper ? hu[nib] : hl[nib];
  endfunction

  function automatic void model_apply(input logic [7:0] w);
    logic [1:0]  ra, rb, rc;
    logic [7:0]  res;
    logic [15:0] prod;
    ra = w[5:4]; rb = w[3:2]; rc = w[1:0];
    res = mdl[ra];
    case (w[7:6])
      2'b00: res = {mdl[ra][3:0], w[3:0]};
      2'b01: res = mdl[rb] + mdl[rc];
      2'b10: begin prod = mdl[rb] * mdl[rc]; res = prod[7:0]; end
      default: return;
    endcase
    mdl[ra] = res;
    led_m   = res;
  endfunction

  task automatic start(input logic [7:0] w);
    @(negedge clk);
    inst_wd  = w;
    inst_vld = 1'b1;
    tx_rdy   = 1'b0;
    @(negedge clk);
    inst_vld = 1'b0;
  endtask

  task automatic issue(input logic [7:0] w, output int bcyc);
    start(w);
    bcyc = 0;
    while (busy && bcyc < 64) begin
      bcyc++;
      @(negedge clk);
    end
  endtask

  // mode 0: ready always, 1: toggling, 2: random
  task automatic collect(input int mode);
    logic pv1, pv2, prdy;
    logic [7:0] pd1, pd2;
    n1 = 0; n2 = 0; hold_err = 0; cyc = 0;
    pv1 = 1'b0; pv2 = 1'b0; prdy = 1'b0; pd1 = 8'h00; pd2 = 8'h00;
    while ((busy || busy2) && cyc < 200) begin
      case (mode)
        0:       tx_rdy = 1'b1;
        1:       tx_rdy = (cyc % 2) == 1;
        default: tx_rdy = 1'($urandom_range(0, 1));
      endcase
      if (pv1 && !prdy && (tx_vld !== 1'b1 || tx_data !== pd1)) hold_err++;
      if (pv2 && !prdy && (tx_vld2 !== 1'b1 || tx_data2 !== pd2)) hold_err++;
      if (tx_vld && tx_rdy && n1 < 16) begin got1[n1] = tx_data; n1++; end
      if (tx_vld2 && tx_rdy && n2 < 16) begin got2[n2] = tx_data2; n2++; end
      pv1 = tx_vld; pd1 = tx_data; pv2 = tx_vld2; pd2 = tx_data2; prdy = tx_rdy;
      cyc++;
      @(negedge clk);
    end
    tx_rdy = 1'b0;
  endtask

  task automatic test_send(input logic [1:0] r, input int mode, input int pre);
    logic [7:0] v;
    v = mdl[r];
    start({2'b11, r, 4'h0});
    for (int i = 0; i < pre; i++) begin
      checks++;
      if (tx_vld !== 1'b1 || tx_data !== exp_byte(v, 0, 1'b1) ||
          tx_vld2 !== 1'b1 || tx_data2 !== exp_byte(v, 0, 1'b0)) begin
        failures++;
        $display("FAIL send_stall R%0d cyc%0d: vld=%b data=%h vld2=%b data2=%h want data=%h data2=%h",
                 r, i, tx_vld, tx_data, tx_vld2, tx_data2, exp_byte(v, 0, 1'b1), exp_byte(v, 0, 1'b0));
      end
      @(negedge clk);
    end
    collect(mode);
    checks++;
    if (cyc >= 200) begin failures++; $display("FAIL send_timeout R%0d: cycles=%0d limit=200", r, cyc); end
    checks++;
    if (n1 != 4 || n2 != 2) begin
      failures++;
      $display("FAIL send_count R%0d: got %0d/%0d bytes, want 4/2", r, n1, n2);
    end
    for (int i = 0; i < 4 && i < n1; i++) begin
      checks++;
      if (got1[i] !== exp_byte(v, i, 1'b1)) begin
        failures++;
        $display("FAIL send_byte R%0d idx%0d: got %h want %h", r, i, got1[i], exp_byte(v, i, 1'b1));
      end
    end
    for (int i = 0; i < 2 && i < n2; i++) begin
      checks++;
      if (got2[i] !== exp_byte(v, i, 1'b0)) begin
        failures++;
        $display("FAIL send_byte_lc R%0d idx%0d: got %h want %h", r, i, got2[i], exp_byte(v, i, 1'b0));
      end
    end
    checks++;
    if (hold_err != 0) begin failures++; $display("FAIL send_hold R%0d: violations=%0d want 0", r, hold_err); end
    if (mode == 0) begin
      checks++;
      if (cyc != 4) begin failures++; $display("FAIL send_b2b R%0d: cycles=%0d want 4", r, cyc); end
    end
    checks++;
    if (led !== led_m || led2 !== led_m) begin
      failures++;
      $display("FAIL send_led R%0d: led=%h led2=%h want %h", r, led, led2, led_m);
    end
  endtask

  task automatic test_exec(input logic [7:0] w);
    int b, want_b;
    want_b = (w[7:6] == 2'b10) ? 8 : 1;
    issue(w, b);
    model_apply(w);
    checks++;
    if (b != want_b) begin failures++; $display("FAIL busy_len inst=%h: got %0d want %0d", w, b, want_b); end
    checks++;
    if (led !== led_m || led2 !== led_m) begin
      failures++;
      $display("FAIL led inst=%h: led=%h led2=%h want %h", w, led, led2, led_m);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inst_vld = 1'b0; inst_wd = 8'h00; tx_rdy = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    led_m = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_vld !== 1'b0 || busy !== 1'b0 || inst_drop !== 1'b0 || led !== 8'h00 || tx_data !== 8'h00 ||
        tx_vld2 !== 1'b0 || busy2 !== 1'b0 || led2 !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: vld=%b busy=%b drop=%b led=%h data=%h, want all zero",
               tx_vld, busy, inst_drop, led, tx_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_send();
    test_exec(8'h13);
    test_exec(8'h1A);
    test_send(2'd1, 0, 0);
    start(8'hD0);
    @(negedge clk);
    checks++;
    if (tx_vld !== 1'b1) begin failures++; $display("FAIL midsend_vld: got %b want 1", tx_vld); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_vld !== 1'b0 || busy !== 1'b0 || led !== 8'h00 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: vld=%b busy=%b led=%h data=%h want 0/0/00/00", tx_vld, busy, led, tx_data);
    end
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    led_m = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    test_send(2'd1, 0, 0);
  endtask

  task automatic test_add_mult();
    test_exec(8'h0F); test_exec(8'h00);
    test_exec(8'h22); test_exec(8'h25);
    test_exec(8'h42);
    test_exec(8'h31); test_exec(8'h33);
    test_exec(8'hBF);
    test_send(2'd0, 0, 5);
  endtask

  task automatic test_drop();
    int b;
    logic [7:0] w;
    w = 8'hAC;
    start(w);
    @(negedge clk);
    @(negedge clk);
    inst_wd = 8'h2F; inst_vld = 1'b1;
    @(negedge clk);
    inst_vld = 1'b0;
    checks++;
    if (inst_drop !== 1'b1 || inst_drop2 !== 1'b1) begin
      failures++;
      $display("FAIL drop_pulse: drop=%b drop2=%b want 1", inst_drop, inst_drop2);
    end
    b = 3;
    while (busy && b < 64) begin b++; @(negedge clk); end
    model_apply(w);
    checks++;
    if (b != 8) begin failures++; $display("FAIL drop_busy_len: got %0d want 8", b); end
    checks++;
    if (inst_drop !== 1'b0) begin failures++; $display("FAIL drop_clear: got %b want 0", inst_drop); end
    checks++;
    if (led !== led_m) begin failures++; $display("FAIL drop_led: got %h want %h", led, led_m); end
    test_send(2'd2, 0, 0);
  endtask

  task automatic test_params_slow_rdy();
    test_exec(8'h1B);
    test_exec(8'h1E);
    test_send(2'd1, 1, 0);
  endtask

  task automatic test_random();
    logic [7:0] w;
    for (int k = 0; k < 30; k++) begin
      w = 8'($urandom);
      if (w[7:6] == 2'b11) w[7] = 1'b0;
      test_exec(w);
      if (k % 6 == 5) test_send(2'($urandom_range(0, 3)), 2, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_send();
    test_add_mult();
    test_drop();
    test_params_slow_rdy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
